// File: rtl/contact_impulse_applier.sv
// contact_impulse_applier: applies one resolved contact to the body-state RAM,
// read-modify-write of body A then body B, with saturating updates.
module contact_impulse_applier #(
  parameter int NUM_BODIES = 16,
  parameter int IDX_W = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    c_valid,
  output logic                    c_ready,
  input  logic [IDX_W-1:0]        c_idx1,
  input  logic [IDX_W-1:0]        c_idx2,
  input  logic signed [23:0]      c_imp1_x,
  input  logic signed [23:0]      c_imp1_y,
  input  logic signed [23:0]      c_imp2_x,
  input  logic signed [23:0]      c_imp2_y,
  input  logic signed [21:0]      c_nudge1_x,
  input  logic signed [21:0]      c_nudge1_y,
  input  logic signed [21:0]      c_nudge2_x,
  input  logic signed [21:0]      c_nudge2_y,
  input  logic signed [10:0]      c_rot1,
  input  logic signed [10:0]      c_rot2,
  input  logic                    c_ignore,
  output logic [IDX_W-1:0]        b_addr,
  output logic                    b_rd_en,
  input  logic signed [23:0]      b_rd_pos_x,
  input  logic signed [23:0]      b_rd_pos_y,
  input  logic signed [23:0]      b_rd_vel_x,
  input  logic signed [23:0]      b_rd_vel_y,
  input  logic signed [10:0]      b_rd_omega,
  input  logic                    b_rd_static,
  output logic                    b_wr_en,
  output logic signed [23:0]      b_wr_pos_x,
  output logic signed [23:0]      b_wr_pos_y,
  output logic signed [23:0]      b_wr_vel_x,
  output logic signed [23:0]      b_wr_vel_y,
  output logic signed [10:0]      b_wr_omega,
  output logic                    busy,
  output logic [15:0]             applied_count,
  output logic [7:0]              dropped_count
);
  if (IDX_W != $clog2(NUM_BODIES)) begin : g_bad_idx_w
    $error("IDX_W must equal clog2(NUM_BODIES)");
  end
  typedef enum logic [2:0] {IDLE, RD1, MOD1, RD2, MOD2} state_t;
  typedef struct packed {
    logic [IDX_W-1:0]   idx1;
    logic [IDX_W-1:0]   idx2;
    logic signed [23:0] imp1_x;
    logic signed [23:0] imp1_y;
    logic signed [23:0] imp2_x;
    logic signed [23:0] imp2_y;
    logic signed [21:0] nudge1_x;
    logic signed [21:0] nudge1_y;
    logic signed [21:0] nudge2_x;
    logic signed [21:0] nudge2_y;
    logic signed [10:0] rot1;
    logic signed [10:0] rot2;
    logic               ignore;
  } contact_t;
  function automatic logic [23:0] sat24(input logic [24:0] v);
    return (v[24] != v[23]) ? {v[24], {23{~v[24]}}} : v[23:0];
  endfunction
  function automatic logic [10:0] sat11(input logic [11:0] v);
    return (v[11] != v[10]) ? {v[11], {10{~v[11]}}} : v[10:0];
  endfunction
  state_t state_q, state_d;
  contact_t ctc_q, ctc_d;
  logic [15:0] applied_q, applied_d;
  logic [7:0] dropped_q, dropped_d;
  logic sel2, mod, wv;
  logic signed [23:0] imp_x, imp_y;
  logic signed [21:0] nud_x, nud_y;
  logic signed [10:0] rot;
  always_comb begin
    state_d = state_q;
    ctc_d = ctc_q;
    applied_d = applied_q;
    dropped_d = dropped_q;
    case (state_q)
      IDLE: if (c_valid) begin
        ctc_d = {c_idx1, c_idx2, c_imp1_x, c_imp1_y, c_imp2_x, c_imp2_y, c_nudge1_x, c_nudge1_y,
                 c_nudge2_x, c_nudge2_y, c_rot1, c_rot2, c_ignore};
        state_d = (c_idx1 == c_idx2) ? IDLE : RD1;
        dropped_d = dropped_q + {7'd0, (c_idx1 == c_idx2) && (dropped_q != 8'hff)};
      end
      RD1: state_d = MOD1;
      MOD1: state_d = RD2;
      RD2: state_d = MOD2;
      MOD2: begin
        state_d = IDLE;
        applied_d = applied_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ctc_q <= '0;
      applied_q <= '0;
      dropped_q <= '0;
    end else begin
      state_q <= state_d;
      ctc_q <= ctc_d;
      applied_q <= applied_d;
      dropped_q <= dropped_d;
    end
  end
  // Reset overrides the strobes combinationally so an in-flight MOD never writes.
  assign sel2 = (state_q == RD2) || (state_q == MOD2);
  assign mod = (state_q == MOD1) || (state_q == MOD2);
  assign wv = mod && !Reset;
  assign c_ready = (state_q == IDLE) && !Reset;
  assign busy = (state_q != IDLE) && !Reset;
  assign b_rd_en = ((state_q == RD1) || (state_q == RD2)) && !Reset;
  assign b_wr_en = wv && !b_rd_static;
  assign b_addr = (Reset || state_q == IDLE) ? '0 : sel2 ? ctc_q.idx2 : ctc_q.idx1;
  assign imp_x = sel2 ? ctc_q.imp2_x : ctc_q.imp1_x;
  assign imp_y = sel2 ? ctc_q.imp2_y : ctc_q.imp1_y;
  assign nud_x = sel2 ? ctc_q.nudge2_x : ctc_q.nudge1_x;
  assign nud_y = sel2 ? ctc_q.nudge2_y : ctc_q.nudge1_y;
  assign rot = sel2 ? ctc_q.rot2 : ctc_q.rot1;
  assign b_wr_pos_x = !wv ? '0 : sat24({b_rd_pos_x[23], b_rd_pos_x} + {{3{nud_x[21]}}, nud_x});
  assign b_wr_pos_y = !wv ? '0 : sat24({b_rd_pos_y[23], b_rd_pos_y} + {{3{nud_y[21]}}, nud_y});
  assign b_wr_vel_x = !wv ? '0 : ctc_q.ignore ? b_rd_vel_x : sat24({b_rd_vel_x[23], b_rd_vel_x} + {imp_x[23], imp_x});
  assign b_wr_vel_y = !wv ? '0 : ctc_q.ignore ? b_rd_vel_y : sat24({b_rd_vel_y[23], b_rd_vel_y} + {imp_y[23], imp_y});
  assign b_wr_omega = !wv ? '0 : ctc_q.ignore ? b_rd_omega : sat11({b_rd_omega[10], b_rd_omega} + {rot[10], rot});
  assign applied_count = applied_q;
  assign dropped_count = dropped_q;
endmodule

// File: tb/tb_contact_impulse_applier.sv
// tb_contact_impulse_applier: directed contacts against a bench RAM model, writes checked by a scoreboard.
module tb_contact_impulse_applier;
  logic Clk, Reset, c_valid, c_ready, c_ignore;
  logic [3:0] c_idx1, c_idx2, b_addr;
  logic signed [23:0] c_imp1_x, c_imp1_y, c_imp2_x, c_imp2_y;
  logic signed [21:0] c_nudge1_x, c_nudge1_y, c_nudge2_x, c_nudge2_y;
  logic signed [10:0] c_rot1, c_rot2;
  logic b_rd_en, b_rd_static, b_wr_en, busy;
  logic signed [23:0] b_rd_pos_x, b_rd_pos_y, b_rd_vel_x, b_rd_vel_y;
  logic signed [10:0] b_rd_omega, b_wr_omega;
  logic signed [23:0] b_wr_pos_x, b_wr_pos_y, b_wr_vel_x, b_wr_vel_y;
  logic [15:0] applied_count;
  logic [7:0] dropped_count;
  contact_impulse_applier #(.NUM_BODIES(16), .IDX_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .c_valid(c_valid), .c_ready(c_ready),
    .c_idx1(c_idx1), .c_idx2(c_idx2),
    .c_imp1_x(c_imp1_x), .c_imp1_y(c_imp1_y), .c_imp2_x(c_imp2_x), .c_imp2_y(c_imp2_y),
    .c_nudge1_x(c_nudge1_x), .c_nudge1_y(c_nudge1_y), .c_nudge2_x(c_nudge2_x), .c_nudge2_y(c_nudge2_y),
    .c_rot1(c_rot1), .c_rot2(c_rot2), .c_ignore(c_ignore),
    .b_addr(b_addr), .b_rd_en(b_rd_en),
    .b_rd_pos_x(b_rd_pos_x), .b_rd_pos_y(b_rd_pos_y), .b_rd_vel_x(b_rd_vel_x), .b_rd_vel_y(b_rd_vel_y),
    .b_rd_omega(b_rd_omega), .b_rd_static(b_rd_static),
    .b_wr_en(b_wr_en), .b_wr_pos_x(b_wr_pos_x), .b_wr_pos_y(b_wr_pos_y),
    .b_wr_vel_x(b_wr_vel_x), .b_wr_vel_y(b_wr_vel_y), .b_wr_omega(b_wr_omega),
    .busy(busy), .applied_count(applied_count), .dropped_count(dropped_count)
  );
  typedef struct {
    logic [3:0] a;
    logic signed [23:0] px, py, vx, vy;
    logic signed [10:0] om;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic ld_en, ld_st;
  logic [3:0] ld_a;
  logic signed [23:0] ld_px, ld_py, ld_vx, ld_vy;
  logic signed [10:0] ld_om;
  logic signed [23:0] m_px[16], m_py[16], m_vx[16], m_vy[16];
  logic signed [10:0] m_om[16];
  logic m_st[16];
  initial Clk = 0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  // Body RAM: one-cycle read latency, writes visible to the next read.
  always @(posedge Clk) begin
    if (ld_en) begin
      m_px[ld_a] <= ld_px; m_py[ld_a] <= ld_py; m_vx[ld_a] <= ld_vx;
      m_vy[ld_a] <= ld_vy; m_om[ld_a] <= ld_om; m_st[ld_a] <= ld_st;
    end
    if (b_wr_en) begin
      m_px[b_addr] <= b_wr_pos_x; m_py[b_addr] <= b_wr_pos_y; m_vx[b_addr] <= b_wr_vel_x;
      m_vy[b_addr] <= b_wr_vel_y; m_om[b_addr] <= b_wr_omega;
    end
    if (b_rd_en) begin
      b_rd_pos_x <= m_px[b_addr]; b_rd_pos_y <= m_py[b_addr]; b_rd_vel_x <= m_vx[b_addr];
      b_rd_vel_y <= m_vy[b_addr]; b_rd_omega <= m_om[b_addr]; b_rd_static <= m_st[b_addr];
    end
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask
  always @(negedge Clk) begin
    if (b_wr_en) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d at cycle %0d, no write required", b_addr, cyc);
      end else begin
        e = q.pop_front();
        chk("wr_data", 128'({b_addr, b_wr_pos_x, b_wr_pos_y, b_wr_vel_x, b_wr_vel_y, b_wr_omega}),
            128'({e.a, e.px, e.py, e.vx, e.vy, e.om}));
        chk("wr_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end
  task automatic expw(input int a, input int px, input int py, input int vx, input int vy, input int om, input int c);
    q.push_back('{4'(a), 24'(px), 24'(py), 24'(vx), 24'(vy), 11'(om), c});
  endtask
  task automatic load(input int a, input int px, input int py, input int vx, input int vy, input int om, input int st);
    @(negedge Clk);
    ld_en = 1; ld_a = 4'(a); ld_px = 24'(px); ld_py = 24'(py);
    ld_vx = 24'(vx); ld_vy = 24'(vy); ld_om = 11'(om); ld_st = st[0];
    @(posedge Clk);
    #1 ld_en = 0;
  endtask
  task automatic send(input int i1, input int i2, input int ix1, input int iy1, input int ix2, input int iy2,
                      input int n1x, input int n1y, input int n2x, input int n2y, input int r1, input int r2,
                      input int ign, input int hold, output int k);
    @(negedge Clk);
    c_valid = 1; c_idx1 = 4'(i1); c_idx2 = 4'(i2);
    c_imp1_x = 24'(ix1); c_imp1_y = 24'(iy1); c_imp2_x = 24'(ix2); c_imp2_y = 24'(iy2);
    c_nudge1_x = 22'(n1x); c_nudge1_y = 22'(n1y); c_nudge2_x = 22'(n2x); c_nudge2_y = 22'(n2y);
    c_rot1 = 11'(r1); c_rot2 = 11'(r2); c_ignore = ign[0];
    for (int i = 0; i < 20 && !c_ready; i++) @(negedge Clk);
    chk("ready_wait", 128'(c_ready), 128'(1));
    k = cyc;
    @(posedge Clk);
    #1 if (hold == 0) c_valid = 0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) @(negedge Clk);
    chk("idle_wait", 128'(busy), 128'(0));
    chk("pending_writes", 128'(q.size()), 128'(0));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int k, k2;
    logic acc;
    Reset = 1; c_valid = 0; c_ignore = 0; c_idx1 = 0; c_idx2 = 0;
    c_imp1_x = 0; c_imp1_y = 0; c_imp2_x = 0; c_imp2_y = 0;
    c_nudge1_x = 0; c_nudge1_y = 0; c_nudge2_x = 0; c_nudge2_y = 0; c_rot1 = 0; c_rot2 = 0;
    ld_en = 0; ld_a = 0; ld_px = 0; ld_py = 0; ld_vx = 0; ld_vy = 0; ld_om = 0; ld_st = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 0;
    @(negedge Clk);
    chk("rst_ready", 128'(c_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_counts", 128'({applied_count, dropped_count}), 128'(0));
    chk("rst_strobes", 128'({b_wr_en, b_rd_en, b_addr}), 128'(0));
    for (int i = 0; i < 16; i++) load(i, 0, 0, 0, 0, 0, 0);
    load(3, 4000, 4000, 100, -50, 10, 0);
    load(5, 1000, -1000, 0, 0, 0, 0);
    send(3, 5, 20, 0, -20, 0, 8, -8, -8, 8, -3, 3, 0, 0, k);
    expw(3, 4008, 3992, 120, -50, 7, k + 2);
    expw(5, 992, -992, -20, 0, 3, k + 4);
    wait_idle();
    chk("basic_applied", 128'(applied_count), 128'(1));
    load(3, 4000, 4000, 100, -50, 10, 0);
    load(5, 1000, -1000, 0, 0, 0, 0);
    send(3, 5, 20, 0, -20, 0, 8, -8, -8, 8, -3, 3, 1, 0, k);
    expw(3, 4008, 3992, 100, -50, 10, k + 2);
    expw(5, 992, -992, 0, 0, 0, k + 4);
    wait_idle();
    chk("ignore_applied", 128'(applied_count), 128'(2));
    load(1, -8388600, 0, 8388600, 0, -1020, 0);
    load(4, 0, 8388600, 0, -8388600, 1020, 0);
    send(1, 4, 100, 0, 0, -100, -100, 0, 0, 2097151, -10, 10, 0, 0, k);
    expw(1, -8388608, 0, 8388607, 0, -1024, k + 2);
    expw(4, 0, 8388607, 0, -8388608, 1023, k + 4);
    wait_idle();
    chk("sat_applied", 128'(applied_count), 128'(3));
    load(6, 10, 20, 30, 40, 5, 0);
    load(5, 1000, -1000, 0, 0, 0, 1);
    send(6, 5, 1, 2, 7, 7, 3, 4, 9, 9, 1, 1, 0, 0, k);
    expw(6, 13, 24, 31, 42, 6, k + 2);
    wait_idle();
    chk("static_applied", 128'(applied_count), 128'(4));
    send(7, 7, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, k);
    @(negedge Clk);
    chk("drop_ready", 128'(c_ready), 128'(1));
    chk("drop_count", 128'(dropped_count), 128'(1));
    acc = 0;
    repeat (5) begin
      @(negedge Clk);
      acc = acc | b_rd_en | busy;
    end
    chk("drop_no_access", 128'(acc), 128'(0));
    chk("drop_applied", 128'(applied_count), 128'(4));
    load(2, 0, 0, 50, -60, 0, 0);
    load(8, 0, 0, 0, 0, 0, 0);
    send(2, 8, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, k);
    expw(2, 0, 0, 55, -55, 0, k + 2);
    expw(8, 0, 0, 0, 0, 0, k + 4);
    send(2, 8, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, k2);
    expw(2, 0, 0, 60, -50, 0, k2 + 2);
    expw(8, 0, 0, 0, 0, 0, k2 + 4);
    c_valid = 0;
    wait_idle();
    chk("b2b_spacing", 128'(k2 - k), 128'(5));
    chk("b2b_applied", 128'(applied_count), 128'(6));
    load(3, 4000, 4000, 100, -50, 10, 0);
    send(3, 5, 20, 0, -20, 0, 8, -8, -8, 8, -3, 3, 0, 0, k);
    @(posedge Clk);
    #1 Reset = 1;
    @(negedge Clk);
    chk("rstmid_wr_en", 128'(b_wr_en), 128'(0));
    chk("rstmid_outputs", 128'({busy, b_addr, b_wr_pos_x, b_wr_vel_x, b_wr_omega}), 128'(0));
    @(posedge Clk);
    #1 Reset = 0;
    @(negedge Clk);
    chk("rstmid_ready", 128'(c_ready), 128'(1));
    chk("rstmid_busy", 128'(busy), 128'(0));
    chk("rstmid_counts", 128'({applied_count, dropped_count}), 128'(0));
    repeat (6) @(negedge Clk);
    chk("rstmid_pending", 128'(q.size()), 128'(0));
    load(3, 4000, 4000, 100, -50, 10, 0);
    load(5, 1000, -1000, 0, 0, 0, 0);
    send(3, 5, 20, 0, -20, 0, 8, -8, -8, 8, -3, 3, 0, 0, k);
    expw(3, 4008, 3992, 120, -50, 7, k + 2);
    expw(5, 992, -992, -20, 0, 3, k + 4);
    wait_idle();
    chk("post_rst_applied", 128'(applied_count), 128'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
